// File: rtl/rf_write_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// rf_write_scheduler_pkg
//   Shared definitions for the register-file write scheduler:
//     state_t   - scheduler FSM encoding (INIT clear sequence, RUN arbitration)
//     rfwa_t    - write-address select codes driven to the existing RFWA mux
//     LINK_REG  - fixed link-register destination
//     REQ_*     - requester bit positions in the request/grant vectors
// ----------------------------------------------------------------------------
package rf_write_scheduler_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_FIELD = 2'b00,
        SEL_LINK  = 2'b01,
        SEL_ZERO  = 2'b10
    } rfwa_t;

    localparam logic [3:0] LINK_REG = 4'hD;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LINK = 1;
    localparam int REQ_LOAD = 2;
    localparam int NUM_REQ  = 3;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// ----------------------------------------------------------------------------
// rf_write_scheduler_if
//   Bundles the three writeback handshakes and the register-file write port.
//   Modports:
//     master - requester / register-file side (drives valid + payload,
//              observes ready, the write port and init_done)
//     slave  - the scheduler itself
//   Signals:
//     alu_valid/alu_addr/alu_data/alu_ready     ALU writeback
//     link_valid/link_data/link_ready           link-register write (r13)
//     load_valid/load_addr/load_data/load_ready memory-load return
//     reg_write/reg_addr/reg_data               registered write port
//     rfwa                                      write-address select code
//     init_done                                 clear sequence complete
// ----------------------------------------------------------------------------
interface rf_write_scheduler_if #(
    parameter int DW = 16
);
    logic          alu_valid;
    logic [3:0]    alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;

    logic          link_valid;
    logic [DW-1:0] link_data;
    logic          link_ready;

    logic          load_valid;
    logic [3:0]    load_addr;
    logic [DW-1:0] load_data;
    logic          load_ready;

    logic          reg_write;
    logic [3:0]    reg_addr;
    logic [DW-1:0] reg_data;
    logic [1:0]    rfwa;
    logic          init_done;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output link_valid, link_data,
        output load_valid, load_addr, load_data,
        input  alu_ready, link_ready, load_ready,
        input  reg_write, reg_addr, reg_data, rfwa, init_done
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  link_valid, link_data,
        input  load_valid, load_addr, load_data,
        output alu_ready, link_ready, load_ready,
        output reg_write, reg_addr, reg_data, rfwa, init_done
    );

endinterface

// File: rtl/rf_write_prio_arbiter.sv
// ----------------------------------------------------------------------------
// rf_write_prio_arbiter
//   Combinational 3-way fixed-priority grant: Load > Link > ALU.
//   alu_first promotes the ALU to top priority for the current cycle only
//   (used by the starvation guard); it has no effect if the ALU is idle.
//   Ports:
//     req       in  [NUM_REQ-1:0]  request vector, indexed by REQ_*
//     alu_first in  1              one-shot ALU priority override
//     gnt       out [NUM_REQ-1:0]  one-hot (or zero) grant vector
// ----------------------------------------------------------------------------
module rf_write_prio_arbiter
    import rf_write_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               alu_first,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no
        // path through the block leaves it unassigned and infers a latch.
        gnt = '0;
        if (alu_first && req[REQ_ALU]) begin
            gnt[REQ_ALU] = 1'b1;
        end else if (req[REQ_LOAD]) begin
            gnt[REQ_LOAD] = 1'b1;
        end else if (req[REQ_LINK]) begin
            gnt[REQ_LINK] = 1'b1;
        end else if (req[REQ_ALU]) begin
            gnt[REQ_ALU] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// ----------------------------------------------------------------------------
// rf_write_scheduler
//   Owns the single register-file write port. After reset it clears
//   r0..r(NREGS-1), one register per cycle, then arbitrates ALU, link and
//   load writebacks (Load > Link > ALU) and issues one registered write per
//   cycle, one cycle after the handshake.
//   Parameters:
//     DW           register data width
//     NREGS        registers cleared after reset (<= 16)
//     ZERO_LOCK    1: ALU/Load writes to r0 are acknowledged but dropped
//     STARVE_LIMIT denied ALU cycles before the one-shot ALU promotion
//   Ports:
//     clk    in  clock
//     reset  in  synchronous active-high reset
//     bus    slave modport of rf_write_scheduler_if (handshakes + write port)
//   Configuration:
//     RF_WRITE_SCHED_STARVE_GUARD_EN - when defined, an ALU requester denied
//     for STARVE_LIMIT consecutive RUN cycles wins the next arbitration once.
// ----------------------------------------------------------------------------
module rf_write_scheduler
    import rf_write_scheduler_pkg::*;
#(
    parameter int DW           = 16,
    parameter int NREGS        = 16,
    parameter int ZERO_LOCK    = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rf_write_scheduler_if.slave  bus
);

    // One extra count value marks the cycle after the last clear write, so
    // the FSM leaves INIT only once that write is already on the port.
    localparam int CNT_W = 5;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   init_cnt;
    logic               init_last;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               alu_first;

    logic               xfer_write;
    logic [3:0]         xfer_addr;
    logic [DW-1:0]      xfer_data;
    rfwa_t              xfer_rfwa;

    assign init_last = (init_cnt == CNT_W'(NREGS));

    // Requests are only visible to the arbiter in RUN; during INIT every
    // requester simply sees ready low and keeps waiting.
    always_comb begin
        req           = '0;
        req[REQ_ALU]  = (state == ST_RUN) && bus.alu_valid;
        req[REQ_LINK] = (state == ST_RUN) && bus.link_valid;
        req[REQ_LOAD] = (state == ST_RUN) && bus.load_valid;
    end

    rf_write_prio_arbiter u_arb (
        .req       (req),
        .alu_first (alu_first),
        .gnt       (gnt)
    );

    assign bus.alu_ready  = gnt[REQ_ALU];
    assign bus.link_ready = gnt[REQ_LINK];
    assign bus.load_ready = gnt[REQ_LOAD];

`ifdef RF_WRITE_SCHED_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    // Saturates at STARVE_LIMIT; the promoted grant itself clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (!bus.alu_valid || gnt[REQ_ALU]) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign alu_first = (starve_cnt == SW'(STARVE_LIMIT));
`else
    assign alu_first = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the selected transfer for this cycle.
    always_comb begin
        state_next = state;
        xfer_write = 1'b0;
        xfer_addr  = '0;
        xfer_data  = '0;
        xfer_rfwa  = SEL_FIELD;

        unique case (state)
            ST_INIT: begin
                if (init_last) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (gnt[REQ_LOAD]) begin
                    xfer_write = 1'b1;
                    xfer_addr  = bus.load_addr;
                    xfer_data  = bus.load_data;
                end else if (gnt[REQ_LINK]) begin
                    xfer_write = 1'b1;
                    xfer_addr  = LINK_REG;
                    xfer_data  = bus.link_data;
                    xfer_rfwa  = SEL_LINK;
                end else if (gnt[REQ_ALU]) begin
                    xfer_write = 1'b1;
                    xfer_addr  = bus.alu_addr;
                    xfer_data  = bus.alu_data;
                end
            end
            default: state_next = ST_INIT;
        endcase

        // r0 is hard-wired zero: the handshake completes, the write is dropped.
        if ((ZERO_LOCK != 0) && (xfer_rfwa == SEL_FIELD) && (xfer_addr == 4'h0)) begin
            xfer_write = 1'b0;
        end
    end

    // Init counter and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt      <= '0;
            bus.reg_write <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_data  <= '0;
            bus.rfwa      <= SEL_FIELD;
            bus.init_done <= 1'b0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (!init_last) begin
                        bus.reg_write <= 1'b1;
                        bus.reg_addr  <= init_cnt[3:0];
                        bus.reg_data  <= '0;
                        bus.rfwa      <= (init_cnt == '0) ? SEL_ZERO : SEL_FIELD;
                        init_cnt      <= init_cnt + 1'b1;
                    end else begin
                        bus.reg_write <= 1'b0;
                        bus.init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    bus.reg_write <= xfer_write;
                    if (xfer_write) begin
                        bus.reg_addr <= xfer_addr;
                        bus.reg_data <= xfer_data;
                        bus.rfwa     <= xfer_rfwa;
                    end
                end
                default: bus.reg_write <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// ----------------------------------------------------------------------------
// tb_rf_write_scheduler
//   Directed bench for rf_write_scheduler. Stimulus pushes each expected
//   register-file write (address, data, select code, output cycle) into a
//   queue; a negedge monitor pops and compares whenever reg_write is high.
//   Ready/init_done/hold values are checked inline by the stimulus.
// ----------------------------------------------------------------------------
module tb_rf_write_scheduler;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic [1:0]  rfwa;
        int          cyc;
    } wr_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    wr_t  exp_q[$];

    rf_write_scheduler_if #(.DW(16)) rif ();

    rf_write_scheduler #(
        .DW           (16),
        .NREGS        (16),
        .ZERO_LOCK    (1),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s, input int c);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.rfwa = s;
        w.cyc  = c;
        exp_q.push_back(w);
    endtask

    // Ends 1 time unit after a rising edge: registered outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] readies();
        return {rif.load_ready, rif.link_ready, rif.alu_ready};
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rif.reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {28'h0, rif.reg_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", rif.reg_addr, w.addr);
                check("wr_data", rif.reg_data, w.data);
                check("wr_rfwa", rif.rfwa, w.rfwa);
                check("wr_cycle", cyc, w.cyc);
            end
        end
    end

    // Called with reset just deasserted; walks the full clear sequence.
    task automatic run_init();
        int base;
        base = cyc;
        for (int i = 0; i < 16; i++) begin
            push_wr(4'(i), 16'h0000, (i == 0) ? 2'b10 : 2'b00, base + 1 + i);
        end
        for (int i = 1; i <= 16; i++) begin
            step();
            check("init_ready", readies(), 3'b000);
            check("init_done_low", rif.init_done, 1'b0);
        end
        step();
        check("init_done_high", rif.init_done, 1'b1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        rif.alu_valid  = 1'b0;
        rif.alu_addr   = 4'h0;
        rif.alu_data   = 16'h0;
        rif.link_valid = 1'b0;
        rif.link_data  = 16'h0;
        rif.load_valid = 1'b0;
        rif.load_addr  = 4'h0;
        rif.load_data  = 16'h0;

        // Reset held two cycles; ALU request pending through reset and INIT.
        step();
        rif.alu_valid = 1'b1;
        rif.alu_addr  = 4'h5;
        rif.alu_data  = 16'h1234;
        step();
        check("rst_reg_write", rif.reg_write, 1'b0);
        check("rst_reg_addr", rif.reg_addr, 4'h0);
        check("rst_reg_data", rif.reg_data, 16'h0);
        check("rst_rfwa", rif.rfwa, 2'b00);
        check("rst_init_done", rif.init_done, 1'b0);
        check("rst_ready", readies(), 3'b000);

        reset = 1'b0;
        run_init();

        // First RUN cycle: waiting ALU request is granted.
        check("alu_ready", readies(), 3'b001);
        push_wr(4'h5, 16'h1234, 2'b00, cyc + 1);
        step();
        rif.alu_valid = 1'b0;

        // All three requesters at once: Load, then Link, then ALU.
        rif.alu_valid  = 1'b1; rif.alu_addr  = 4'h7; rif.alu_data  = 16'h0A0A;
        rif.link_valid = 1'b1; rif.link_data = 16'h0BEE;
        rif.load_valid = 1'b1; rif.load_addr = 4'h3; rif.load_data = 16'h0C0C;
        #1;
        check("prio_load", readies(), 3'b100);
        push_wr(4'h3, 16'h0C0C, 2'b00, cyc + 1);
        step();
        rif.load_valid = 1'b0;
        #1;
        check("prio_link", readies(), 3'b010);
        push_wr(4'hD, 16'h0BEE, 2'b01, cyc + 1);
        step();
        rif.link_valid = 1'b0;
        #1;
        check("prio_alu", readies(), 3'b001);
        push_wr(4'h7, 16'h0A0A, 2'b00, cyc + 1);
        step();
        rif.alu_valid = 1'b0;
        #1;
        check("idle_ready", readies(), 3'b000);
        step();
        step();
        check("hold_write", rif.reg_write, 1'b0);
        check("hold_addr", rif.reg_addr, 4'h7);
        check("hold_data", rif.reg_data, 16'h0A0A);

        // Back-to-back ALU grants.
        rif.alu_valid = 1'b1; rif.alu_addr = 4'h1; rif.alu_data = 16'h1111;
        #1;
        check("b2b_first", readies(), 3'b001);
        push_wr(4'h1, 16'h1111, 2'b00, cyc + 1);
        step();
        rif.alu_addr = 4'h2; rif.alu_data = 16'h2222;
        #1;
        check("b2b_second", readies(), 3'b001);
        push_wr(4'h2, 16'h2222, 2'b00, cyc + 1);
        step();
        rif.alu_valid = 1'b0;

        // Zero lock: r0 writes from ALU and Load are acknowledged, dropped.
        rif.alu_valid = 1'b1; rif.alu_addr = 4'h0; rif.alu_data = 16'hFFFF;
        #1;
        check("zl_alu_ready", rif.alu_ready, 1'b1);
        step();
        rif.alu_valid = 1'b0;
        check("zl_alu_write", rif.reg_write, 1'b0);
        rif.load_valid = 1'b1; rif.load_addr = 4'h0; rif.load_data = 16'h5A5A;
        #1;
        check("zl_load_ready", rif.load_ready, 1'b1);
        step();
        rif.load_valid = 1'b0;
        check("zl_load_write", rif.reg_write, 1'b0);
        check("zl_addr_hold", rif.reg_addr, 4'h2);

        // Reset in RUN with a load pending, then again at init counter 7.
        rif.load_valid = 1'b1; rif.load_addr = 4'h9; rif.load_data = 16'hABCD;
        reset = 1'b1;
        step();
        check("rst_run_write", rif.reg_write, 1'b0);
        check("rst_run_done", rif.init_done, 1'b0);
        step();
        reset = 1'b0;
        begin
            int base;
            base = cyc;
            for (int i = 0; i < 7; i++) begin
                push_wr(4'(i), 16'h0000, (i == 0) ? 2'b10 : 2'b00, base + 1 + i);
            end
        end
        for (int i = 1; i <= 7; i++) begin
            step();
            check("init7_ready", readies(), 3'b000);
        end
        reset = 1'b1;
        step();
        check("rst_init_write", rif.reg_write, 1'b0);
        check("rst_init_addr", rif.reg_addr, 4'h0);
        reset = 1'b0;
        run_init();
        check("pending_load_ready", readies(), 3'b100);
        push_wr(4'h9, 16'hABCD, 2'b00, cyc + 1);
        step();
        rif.load_valid = 1'b0;

        // Continuous Load traffic against a waiting ALU.
        rif.load_valid = 1'b1; rif.load_addr = 4'h8; rif.load_data = 16'h7777;
        rif.alu_valid  = 1'b1; rif.alu_addr  = 4'h3; rif.alu_data  = 16'h5555;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] want;
`ifdef RF_WRITE_SCHED_STARVE_GUARD_EN
            want = (i == 4) ? 3'b001 : 3'b100;
`else
            want = 3'b100;
`endif
            #1;
            check("starve_ready", readies(), want);
            if (want == 3'b001) push_wr(4'h3, 16'h5555, 2'b00, cyc + 1);
            else                push_wr(4'h8, 16'h7777, 2'b00, cyc + 1);
            step();
        end
        rif.load_valid = 1'b0;
        rif.alu_valid  = 1'b0;
        #1;
        check("final_idle_ready", readies(), 3'b000);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            step();
        end
        step();
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
